// File: rtl/mux81_arb_pkg.sv
// Shared definitions for the mux81 round-robin arbiter: widths, FSM state type
// and the rotating-priority search used to pick the next owner.
package mux81_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Returns {found, index} of the first set request scanning start, start+1, ... mod 8.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [SEL_W-1:0] start);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = start + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux81_df.sv
// Dataflow 8:1 single-bit multiplexer; s picks which of i0..i7 reaches y.
module mux81_df
  import mux81_arb_pkg::*;
(
  input  logic             i0,
  input  logic             i1,
  input  logic             i2,
  input  logic             i3,
  input  logic             i4,
  input  logic             i5,
  input  logic             i6,
  input  logic             i7,
  input  logic [SEL_W-1:0] s,
  output logic             y
);

  assign y = s[2] ? (s[1] ? (s[0] ? i7 : i6) : (s[0] ? i5 : i4))
                  : (s[1] ? (s[0] ? i3 : i2) : (s[0] ? i1 : i0));

endmodule

// File: rtl/mux81_rr_arb.sv
// Round-robin arbiter that owns the select of a mux81_df; each grant is bounded
// to HOLD_MAX cycles so no requester can starve the others.
module mux81_rr_arb
  import mux81_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             y_valid,
  output logic             y
);

  localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic [SEL_W:0]   pick;
  logic             found;
  logic [SEL_W-1:0] win;
  logic             arbNow;
  logic             muxY;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  // While granted, ptr already sits at owner+1, so one search covers both states.
  assign pick  = rr_pick(req, ptr_q);
  assign found = pick[SEL_W];
  assign win   = pick[SEL_W-1:0];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    arbNow  = 1'b0;

    case (state_q)
      IDLE:  arbNow = 1'b1;
      GRANT: begin
        if (req[sel_q] && (hold_q != HOLD_LAST)) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          arbNow = 1'b1;
        end
      end
      default: arbNow = 1'b1;
    endcase

    if (arbNow) begin
      hold_d = '0;
      if (found) begin
        state_d = GRANT;
        gnt_d   = N_REQ'(1) << win;
        sel_d   = win;
        ptr_d   = win + SEL_W'(1);
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = '0;
      end
    end
  end

  mux81_df u_mux (
    .i0 (din[0]),
    .i1 (din[1]),
    .i2 (din[2]),
    .i3 (din[3]),
    .i4 (din[4]),
    .i5 (din[5]),
    .i6 (din[6]),
    .i7 (din[7]),
    .s  (sel_q),
    .y  (muxY)
  );

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign y_valid = (gnt_q != '0);
  assign y       = y_valid & muxY;

endmodule

// File: tb/tb_mux81_rr_arb.sv
// Bench for mux81_rr_arb: directed scenarios then random traffic, all compared
// against an owner/cycle-count model of the round-robin rules.
module tb_mux81_rr_arb;

  localparam int HOLD_MAX = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] din;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       y_valid;
  logic       y;

  int checkCount = 0;
  int passCount  = 0;

  int owner     = -1;
  int heldCyc   = 0;
  int searchPtr = 0;

  mux81_rr_arb #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .din     (din),
    .gnt     (gnt),
    .sel     (sel),
    .y_valid (y_valid),
    .y       (y)
  );

  always #5 clk = ~clk;

  function automatic int findNext(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  // Owner keeps the mux until it drops its request or has held it HOLD_MAX cycles.
  task automatic modelEdge(input logic r, input logic [7:0] rq);
    int w;
    if (r) begin
      owner = -1; heldCyc = 0; searchPtr = 0;
    end else if (owner >= 0 && rq[owner] && heldCyc < HOLD_MAX) begin
      heldCyc++;
    end else begin
      w = findNext(rq, (owner >= 0) ? (owner + 1) % 8 : searchPtr);
      if (w < 0) begin
        owner = -1; heldCyc = 0;
      end else begin
        owner = w; heldCyc = 1; searchPtr = (w + 1) % 8;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] eGnt;
    logic [2:0] eSel;
    logic       eVal;
    logic       eY;
    eGnt = (owner >= 0) ? 8'(1 << owner) : 8'h00;
    eSel = (owner >= 0) ? 3'(owner) : 3'd0;
    eVal = (owner >= 0);
    eY   = (owner >= 0) ? din[owner] : 1'b0;
    checkCount++;
    assert (gnt === eGnt) passCount++;
    else $error("[TB] FAIL %s gnt observed=%h expected=%h", tag, gnt, eGnt);
    checkCount++;
    assert (sel === eSel) passCount++;
    else $error("[TB] FAIL %s sel observed=%0d expected=%0d", tag, sel, eSel);
    checkCount++;
    assert (y_valid === eVal) passCount++;
    else $error("[TB] FAIL %s y_valid observed=%b expected=%b", tag, y_valid, eVal);
    checkCount++;
    assert (y === eY) passCount++;
    else $error("[TB] FAIL %s y observed=%b expected=%b", tag, y, eY);
  endtask

  task automatic expectGnt(input string tag, input logic [7:0] want);
    checkCount++;
    assert (gnt === want) passCount++;
    else $error("[TB] FAIL %s gnt observed=%h expected=%h", tag, gnt, want);
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] rq, input logic [7:0] d,
                               input string tag);
    @(negedge clk);
    rst = r; req = rq; din = d;
    @(posedge clk);
    modelEdge(r, rq);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; din = 8'h00;

    applyStimulus(1'b1, 8'h10, 8'h10, "reset0");
    applyStimulus(1'b1, 8'h10, 8'h10, "reset1");
    expectGnt("resetGnt", 8'h00);
    applyStimulus(1'b0, 8'h10, 8'h10, "single");
    expectGnt("singleGnt", 8'h10);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h10, 8'h10, "singleRegrant");
      expectGnt("singleNoGap", 8'h10);
    end

    applyStimulus(1'b1, 8'hFF, 8'hA5, "rotReset");
    for (int k = 0; k < 36; k++) begin
      applyStimulus(1'b0, 8'hFF, 8'(k * 37), "rotation");
      expectGnt("rotOrder", 8'(1 << ((k / HOLD_MAX) % 8)));
    end

    applyStimulus(1'b1, 8'h00, 8'h00, "earlyReset");
    applyStimulus(1'b0, 8'h08, 8'h48, "earlyOwner3");
    expectGnt("earlyOwner3Gnt", 8'h08);
    applyStimulus(1'b0, 8'h40, 8'h48, "earlyRelease");
    expectGnt("earlyTo6", 8'h40);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h40, 8'h40, "earlyHold");

    applyStimulus(1'b1, 8'h00, 8'h00, "wrapReset");
    applyStimulus(1'b0, 8'h80, 8'h02, "wrapOwner7");
    expectGnt("wrapOwner7Gnt", 8'h80);
    applyStimulus(1'b0, 8'h06, 8'h02, "wrapSearch");
    expectGnt("wrapTo1", 8'h02);

    applyStimulus(1'b0, 8'h00, 8'hFF, "allDrop");
    expectGnt("allDropGnt", 8'h00);

    applyStimulus(1'b1, 8'h00, 8'h00, "midReset0");
    applyStimulus(1'b0, 8'h20, 8'hFF, "midOwner5");
    expectGnt("midOwner5Gnt", 8'h20);
    applyStimulus(1'b1, 8'hFF, 8'hFF, "midReset");
    expectGnt("midResetGnt", 8'h00);
    applyStimulus(1'b0, 8'hFF, 8'hFF, "midAfter");
    expectGnt("midFirstIs0", 8'h01);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] rq;
      rq = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 3) == 0) rq = 8'h00;
      applyStimulus(($urandom_range(0, 60) == 0), rq, 8'($urandom), "random");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
